memcmd_issuer: RTL

Controller-side command issuer for one DRAM bank. It turns a valid/ready stream of read/write requests (row, column) into single-cycle ACT/RD/WR/PR/REF command strobes, driven straight into the bank timing FSM. It enforces tRCD, tCL, tRP and tRFC internally, keeps the last row open (open-page policy), and inserts a refresh every T_REFI cycles.

---
 rtl/memcmd_pkg.sv | 30 +++
 rtl/memcmd_issuer_refresh_timer.sv | 33 +++
 rtl/memcmd_issuer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/memcmd_pkg.sv
// Shared types and constants for the single-bank DRAM command issuer.
package memcmd_pkg;

    localparam int unsigned CNTW = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACT_WAIT = 3'd1,
        S_CL_WAIT  = 3'd2,
        S_ACTIVE   = 3'd3,
        S_PRE_WAIT = 3'd4,
        S_REF_WAIT = 3'd5
    } state_t;

    // One-hot command word: bit order ACT, RD, WR, PR, REF
    typedef enum logic [4:0] {
        CMD_NONE = 5'b00000,
        CMD_ACT  = 5'b00001,
        CMD_RD   = 5'b00010,
        CMD_WR   = 5'b00100,
        CMD_PR   = 5'b01000,
        CMD_REF  = 5'b10000
    } cmd_t;

    // Down-counters expire at zero, so a wait of N cycles loads N-1.
    function automatic logic [CNTW-1:0] cnt_load(input int unsigned cycles);
        return CNTW'(cycles - 1);
    endfunction

endpackage

// File: rtl/memcmd_issuer_refresh_timer.sv
// Refresh interval counter; raises pending every T_REFI cycles until cleared.
module refresh_timer
    import memcmd_pkg::*;
#(
    parameter int unsigned T_REFI = 7800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic pending
);

    logic [CNTW-1:0] refi;
    logic            expire;

    assign expire = (refi == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi    <= cnt_load(T_REFI);
            pending <= 1'b0;
        end else begin
            refi <= expire ? cnt_load(T_REFI) : refi - 1'b1;
            // A fresh expiry wins over a clear in the same cycle
            if (expire) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memcmd_issuer.sv
// Single-bank DRAM command issuer: open-page policy, registered command strobes,
// internal tRCD/tCL/tRP/tRFC waits and periodic refresh.
module memcmd_issuer
    import memcmd_pkg::*;
#(
    parameter int unsigned T_CL   = 17,
    parameter int unsigned T_RCD  = 17,
    parameter int unsigned T_RP   = 17,
    parameter int unsigned T_RFC  = 347,
    parameter int unsigned T_REFI = 7800,
    parameter int unsigned ROWW   = 16,
    parameter int unsigned COLW   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [ROWW-1:0] req_row,
    input  logic [COLW-1:0] req_col,
    output logic            ACT,
    output logic            RD,
    output logic            WR,
    output logic            PR,
    output logic            REF,
    output logic [ROWW-1:0] cmd_row,
    output logic [COLW-1:0] cmd_col,
    output logic            req_done,
    output logic [2:0]      state
);

    state_t          cur_state, nxt_state;
    cmd_t            cmd, nxt_cmd;
    logic [CNTW-1:0] cnt, nxt_cnt;
    logic [ROWW-1:0] open_row, nxt_open_row;
    logic [COLW-1:0] col, nxt_col;
    logic            done, nxt_done;
    logic            ref_pending;
    logic            row_hit;

    refresh_timer #(
        .T_REFI(T_REFI)
    ) u_refresh_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (nxt_cmd == CMD_REF),
        .pending(ref_pending)
    );

    assign row_hit   = (req_row == open_row);
    assign req_ready = (cur_state == S_ACTIVE) && !ref_pending && row_hit;

    always_comb begin
        nxt_state    = cur_state;
        nxt_cmd      = CMD_NONE;
        nxt_cnt      = cnt;
        nxt_open_row = open_row;
        nxt_col      = col;
        nxt_done     = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (ref_pending) begin
                    nxt_cmd   = CMD_REF;
                    nxt_state = S_REF_WAIT;
                    nxt_cnt   = cnt_load(T_RFC);
                end else if (req_valid) begin
                    nxt_cmd      = CMD_ACT;
                    nxt_open_row = req_row;
                    nxt_state    = S_ACT_WAIT;
                    nxt_cnt      = cnt_load(T_RCD);
                end
            end
            S_ACT_WAIT: begin
                if (cnt == '0) begin
                    nxt_state = S_CL_WAIT;
                    nxt_cnt   = cnt_load(T_CL);
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            S_CL_WAIT: begin
                if (cnt == '0) begin
                    nxt_state = S_ACTIVE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                // Refresh and row misses both close the page the same way
                if (ref_pending || (req_valid && !row_hit)) begin
                    nxt_cmd   = CMD_PR;
                    nxt_state = S_PRE_WAIT;
                    nxt_cnt   = cnt_load(T_RP);
                end else if (req_valid) begin
                    nxt_cmd  = req_we ? CMD_WR : CMD_RD;
                    nxt_col  = req_col;
                    nxt_done = 1'b1;
                end
            end
            S_PRE_WAIT, S_REF_WAIT: begin
                if (cnt == '0) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            cmd       <= CMD_NONE;
            cnt       <= '0;
            open_row  <= '0;
            col       <= '0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cmd       <= nxt_cmd;
            cnt       <= nxt_cnt;
            open_row  <= nxt_open_row;
            col       <= nxt_col;
            done      <= nxt_done;
        end
    end

    assign ACT      = (cmd == CMD_ACT);
    assign RD       = (cmd == CMD_RD);
    assign WR       = (cmd == CMD_WR);
    assign PR       = (cmd == CMD_PR);
    assign REF      = (cmd == CMD_REF);
    assign cmd_row  = open_row;
    assign cmd_col  = col;
    assign req_done = done;
    assign state    = cur_state;

endmodule
